// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with a registered fill level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable registered or first-word-fall-through read port.
module sync_fifo_level #(
   parameter int W        = 3,
   parameter int B        = 16,
   parameter int FWFT     = 0,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         enWr,
   input  logic [B-1:0] dataW,
   input  logic         enRd,
   output logic [B-1:0] dataR,
   output logic         empty,
   output logic         full,
   output logic         almostEmpty,
   output logic         almostFull,
   output logic [W:0]   level,
   output logic         overflow,
   output logic         underflow,
   input  logic         clrErr
);

   localparam int         D        = 2 ** W;
   localparam logic [W:0] LVL_FULL = (W+1)'(D);
   localparam logic [W:0] LVL_AF   = (W+1)'(AF_LEVEL);
   localparam logic [W:0] LVL_AE   = (W+1)'(AE_LEVEL);

   logic [B-1:0] r_mem [D];
   logic [W-1:0] r_wptr;
   logic [W-1:0] r_rptr;
   logic [W:0]   r_level;
   logic         r_empty;
   logic         r_full;
   logic         r_ae;
   logic         r_af;
   logic         r_ovf;
   logic         r_udf;

   logic         w_wr_acc;
   logic         w_rd_acc;
   logic [W:0]   w_level_nxt;

   // No bypass: acceptance depends only on the registered full/empty state.
   assign w_wr_acc = enWr & ~r_full;
   assign w_rd_acc = enRd & ~r_empty;

   always_comb begin
      w_level_nxt = r_level;
      if (w_wr_acc && !w_rd_acc) begin
         w_level_nxt = r_level + (W+1)'(1);
      end else if (w_rd_acc && !w_wr_acc) begin
         w_level_nxt = r_level - (W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wptr] <= dataW;
      end
   end

   // Status flags are derived from the next level so they change on the same edge as level.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
         r_ae    <= 1'b1;
         r_af    <= 1'b0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wptr <= r_wptr + W'(1);
         end
         if (w_rd_acc) begin
            r_rptr <= r_rptr + W'(1);
         end
         r_level <= w_level_nxt;
         r_empty <= (w_level_nxt == '0);
         r_full  <= (w_level_nxt == LVL_FULL);
         r_ae    <= (w_level_nxt <= LVL_AE);
         r_af    <= (w_level_nxt >= LVL_AF);
         if (enWr && r_full) begin
            r_ovf <= 1'b1;
         end else if (clrErr) begin
            r_ovf <= 1'b0;
         end
         if (enRd && r_empty) begin
            r_udf <= 1'b1;
         end else if (clrErr) begin
            r_udf <= 1'b0;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign dataR = r_mem[r_rptr];
      end else begin : g_reg
         logic [B-1:0] r_dataR;
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_dataR <= '0;
            end else if (w_rd_acc) begin
               r_dataR <= r_mem[r_rptr];
            end
         end
         assign dataR = r_dataR;
      end
   endgenerate

   assign empty       = r_empty;
   assign full        = r_full;
   assign almostEmpty = r_ae;
   assign almostFull  = r_af;
   assign level       = r_level;
   assign overflow    = r_ovf;
   assign underflow   = r_udf;

endmodule

// File: doc/sync_fifo_level.md
Name: sync_fifo_level

Overview:
Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for same-domain links between producers and consumers on the on-chip communication path.
- Adds a fill-level output, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags.
- Read port mode is selectable: registered-read or first-word-fall-through (FWFT).
- The existing scenario-generation and reporting benches drive and check it through the same enWr/enRd/dataW/dataR handshake.

Parameters:
- W, 3: log2 of depth. Depth D = 2**W. Legal W >= 1.
- B, 16: data width in bits.
- FWFT, 0: 0 = registered read (dataR updates one cycle after an accepted read); 1 = first-word-fall-through.
- AF_LEVEL, 6: almostFull asserts when level >= AF_LEVEL. Legal range 1..D.
- AE_LEVEL, 1: almostEmpty asserts when level <= AE_LEVEL. Legal range 0..D-1.

Ports:
- clk  in  1  Single clock; all state changes on its rising edge.
- rstn  in  1  Asynchronous, active-low reset.
- enWr  in  1  Write request.
- dataW  in  B  Write data.
- enRd  in  1  Read request.
- dataR  out  B  Read data.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds D entries.
- almostEmpty  out  1  level <= AE_LEVEL.
- almostFull  out  1  level >= AF_LEVEL.
- level  out  W+1  Current entry count, 0..D.
- overflow  out  1  Sticky: a write was attempted while full.
- underflow  out  1  Sticky: a read was attempted while empty.
- clrErr  in  1  Synchronous clear of overflow and underflow.

Behaviour:
Storage and pointers
- Storage is D x B bits, not reset.
- Write pointer and read pointer are each W bits and wrap modulo D.
- level is a registered W+1-bit counter.

Acceptance rules
- Write is accepted when enWr=1 and full=0. An accepted write stores dataW at the write pointer and increments the write pointer.
- Read is accepted when enRd=1 and empty=0. An accepted read increments the read pointer.
- No bypass:
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle.
- level update per cycle:
  - +1 for a write-only accept.
  - -1 for a read-only accept.
  - Unchanged when both or neither are accepted.
- level never exceeds D and never goes below 0.

Status outputs
- All status outputs are registered and reflect the post-edge level:
  - empty = (level == 0)
  - full = (level == D)
  - almostEmpty = (level <= AE_LEVEL)
  - almostFull = (level >= AF_LEVEL)

Read data, FWFT=0
- On an accepted read, dataR loads the head entry at that edge, so data is visible one cycle after enRd.
- dataR holds its value otherwise, including on rejected reads.

Read data, FWFT=1
- dataR shows the head entry combinationally while empty=0.
- The first write into an empty FIFO is visible on dataR in the cycle after the write edge, coincident with empty falling.
- An accepted read advances dataR to the next entry after the edge.
- While empty=1, dataR is unspecified; benches must not check it.

Error flags
- overflow is set at the edge where enWr=1 and full=1.
- underflow is set at the edge where enRd=1 and empty=1.
- Both flags stay set until clrErr=1 at an edge.
- If set and clear occur in the same cycle, set wins.
- Rejected requests never modify storage, pointers or level.

Reset
- Asserting rstn=0 at any time, including mid-burst, immediately forces:
  - pointers = 0, level = 0
  - empty = 1, full = 0, almostEmpty = 1, almostFull = 0
  - overflow = 0, underflow = 0
  - dataR = 0 in FWFT=0 mode
- Storage contents are lost logically.
- First accepted operation is possible at the first rising edge after rstn returns to 1.

Test Plan:
1. W=3, B=16, FWFT=0. Write 0x0000..0x0007 on 8 consecutive cycles, then read 8.
   -> full=1 after the 8th write edge, level=8.
   -> dataR sequence 0..7, each one cycle after enRd.
   -> empty=1 after the last read.
2. Fill to 8, then assert enWr for 1 cycle with dataW=0xCAFE.
   -> overflow=1, level stays 8, 0xCAFE is never read out.
   -> clrErr pulse clears overflow.
3. Empty FIFO, enRd for 2 cycles.
   -> underflow=1, level=0, dataR unchanged.
   -> Then enRd=1 with clrErr=1 in the same cycle -> underflow stays 1 (set wins).
4. Simultaneous traffic:
   -> At level=4, enWr=enRd=1 for 20 cycles -> level stays 4, data order preserved across pointer wrap.
   -> At level=8, enWr=enRd=1 -> read accepted, write rejected, level=7.
5. Thresholds, AF_LEVEL=6, AE_LEVEL=1:
   -> Stepping level 0..8 gives almostEmpty=1 at levels 0-1 and almostFull=1 at levels 6-8.
   -> Flags track level on the same edge as level.
6. FWFT=1: write 0x00A5 into an empty FIFO.
   -> Next cycle empty=0 and dataR=0x00A5 with no enRd.
   -> Assert rstn=0 at level 5 mid-burst -> level=0, empty=1 immediately, without waiting for a clock edge.
